// File: rtl/fetch_unit.sv
// Purpose : instruction fetch stage; owns the PC, drives imem, buffers one instruction for decode.
// Latency : first instr_valid RD_WAIT cycles after reset releases; steady state one instr per RD_WAIT cycles.
// Backpr. : when decode holds instr_ready low with a full buffer, the address is held (STALL) until a transfer.
//
// Ports:
//   CLK, resetl          clock and synchronous active-low reset
//   startPC_sel, startPC reset PC select (1: startPC, 0: START_PC_DEFAULT)
//   imem_addr/imem_data  instruction memory address (== pc register) and returned word
//   instr, instr_pc,     one-entry output buffer with valid/ready handshake
//   instr_valid/ready
//   redirect/redirect_pc flush buffer and restart fetch at redirect_pc (low 2 bits forced to 0)
// Optional (macro FETCH_STATS_EN): fetch_count (transfers, wrapping) and
//   flush_count (redirects that discarded a valid buffer, saturating).
module fetch_unit #(
    parameter int unsigned RD_WAIT          = 2,
    parameter logic [63:0] START_PC_DEFAULT = 64'h0
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        startPC_sel,
    input  logic [63:0] startPC,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
`endif
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(RD_WAIT - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_pc;
    logic [31:0] r_instr;
    logic [63:0] r_instr_pc;
    logic        r_instr_valid;

    logic        w_xfer;
    logic        w_free;
    logic        w_cnt_done;
    logic [63:0] w_start_pc;
    logic [63:0] w_pc_next;
    logic [63:0] w_redirect_pc;

    assign w_xfer        = r_instr_valid && instr_ready;
    assign w_free        = !r_instr_valid || w_xfer;
    assign w_cnt_done    = (r_cnt == CNT_LAST);
    assign w_start_pc    = startPC_sel ? startPC : START_PC_DEFAULT;
    // 64-bit add wraps naturally from ...FFFC to 0.
    assign w_pc_next     = r_pc + 64'd4;
    assign w_redirect_pc = redirect_pc & ~64'h3;

    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_state       <= ST_FETCH;
            r_cnt         <= 4'd0;
            r_pc          <= w_start_pc;
            r_instr       <= 32'h0;
            r_instr_pc    <= 64'h0;
            r_instr_valid <= 1'b0;
        end else if (redirect) begin
            // Redirect discards the buffer outright; a same-cycle ready is not a transfer
            // and any capture due this cycle is dropped.
            r_state       <= ST_FETCH;
            r_cnt         <= 4'd0;
            r_pc          <= w_redirect_pc;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_cnt_done) begin
                        if (w_free) begin
                            r_instr       <= imem_data;
                            r_instr_pc    <= r_pc;
                            r_instr_valid <= 1'b1;
                            r_pc          <= w_pc_next;
                            r_cnt         <= 4'd0;
                        end else begin
                            // Data is ready but the buffer is occupied: hold the address.
                            r_state <= ST_STALL;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_xfer) begin
                            r_instr_valid <= 1'b0;
                        end
                    end
                end
                ST_STALL: begin
                    // Address has been held the full read time, so imem_data is still good.
                    if (w_xfer) begin
                        r_instr       <= imem_data;
                        r_instr_pc    <= r_pc;
                        r_instr_valid <= 1'b1;
                        r_pc          <= w_pc_next;
                        r_cnt         <= 4'd0;
                        r_state       <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_count;
    logic [15:0] r_flush_count;

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_fetch_count <= 32'h0;
            r_flush_count <= 16'h0;
        end else if (redirect) begin
            if (r_instr_valid && (r_flush_count != 16'hFFFF)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end else if (w_xfer) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign flush_count = r_flush_count;
`endif

endmodule
